// File: rtl/samp_pkg.sv
// Shared sample-path types and default sizing for the I/Q buffering stage.
// samp_t keeps the legacy fixed-width {I,Q} layout used elsewhere in the codebase.
package samp_pkg;

  localparam int unsigned SAMP_W_DEF = 24;
  localparam int unsigned DEPTH_DEF  = 4;

  // Fixed-width {I,Q} record. Parametrised blocks build the same {I,Q} packing
  // locally as a 2*SAMP_W vector, with I in the upper half.
  typedef struct packed {
    logic [SAMP_W_DEF-1:0] i;
    logic [SAMP_W_DEF-1:0] q;
  } samp_t;

endpackage

// File: rtl/fifo_ptr_ctl.sv
// Pointer, flag and occupancy control for iq_sample_fifo.
// Optional sticky error flags are built when IQ_FIFO_ERR_EN is defined.
module fifo_ptr_ctl
  import samp_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned AFULL_TH = DEPTH - 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     PushIn,
  input  logic                     PullOut,
  input  logic                     ErrClr,
  output logic                     accept_w,
  output logic [$clog2(DEPTH)-1:0] wr_idx,
  output logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     Empty,
  output logic                     Full,
  output logic                     AlmostFull,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic                     Underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] TH = PW'(AFULL_TH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          accept_r;

  // Flags depend on the registered pointers only; the MSB is the wrap bit.
  always_comb begin
    Empty      = (wr_ptr == rd_ptr);
    Full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    Count      = wr_ptr - rd_ptr;
    AlmostFull = (Count >= TH);
    wr_idx     = wr_ptr[AW-1:0];
    rd_idx     = rd_ptr[AW-1:0];
  end

  always_comb begin
    accept_w = PushIn && (!Full || PullOut);
    accept_r = PullOut && !Empty;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept_w) wr_ptr <= wr_ptr + PW'(1);
      if (accept_r) rd_ptr <= rd_ptr + PW'(1);
    end
  end

`ifdef IQ_FIFO_ERR_EN
  logic drop_w;
  logic drop_r;

  always_comb begin
    drop_w = PushIn && Full && !PullOut;
    drop_r = PullOut && Empty;
  end

  // A set event in the same cycle as ErrClr takes priority.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (drop_w)      Overflow <= 1'b1;
      else if (ErrClr) Overflow <= 1'b0;
      if (drop_r)      Underflow <= 1'b1;
      else if (ErrClr) Underflow <= 1'b0;
    end
  end
`else
  logic unused_errclr;

  always_comb begin
    unused_errclr = ErrClr;
    Overflow      = 1'b0;
    Underflow     = 1'b0;
  end
`endif

endmodule

// File: rtl/iq_sample_fifo.sv
// First-word-fall-through FIFO for complex I/Q samples: storage and head-entry output.
// Sticky Overflow/Underflow flags are built only when IQ_FIFO_ERR_EN is defined.
module iq_sample_fifo
  import samp_pkg::*;
#(
  parameter int unsigned SAMP_W   = SAMP_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned AFULL_TH = DEPTH - 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   PushIn,
  input  logic [SAMP_W-1:0]      SampI,
  input  logic [SAMP_W-1:0]      SampQ,
  input  logic                   PullOut,
  output logic [SAMP_W-1:0]      OutI,
  output logic [SAMP_W-1:0]      OutQ,
  output logic                   Empty,
  output logic                   Full,
  output logic                   AlmostFull,
  output logic [$clog2(DEPTH):0] Count,
  input  logic                   ErrClr,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [2*SAMP_W-1:0] mem [DEPTH];
  logic [2*SAMP_W-1:0] head;
  logic                accept_w;
  logic [AW-1:0]       wr_idx;
  logic [AW-1:0]       rd_idx;

  fifo_ptr_ctl #(
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH)
  ) u_ptr_ctl (
    .Clk        (Clk),
    .Reset      (Reset),
    .PushIn     (PushIn),
    .PullOut    (PullOut),
    .ErrClr     (ErrClr),
    .accept_w   (accept_w),
    .wr_idx     (wr_idx),
    .rd_idx     (rd_idx),
    .Empty      (Empty),
    .Full       (Full),
    .AlmostFull (AlmostFull),
    .Count      (Count),
    .Overflow   (Overflow),
    .Underflow  (Underflow)
  );

  // Storage is left unreset; the pointers alone define valid contents.
  always_ff @(posedge Clk) begin
    if (accept_w) mem[wr_idx] <= {SampI, SampQ};
  end

  always_comb begin
    head = mem[rd_idx];
    OutI = '0;
    OutQ = '0;
    if (!Empty) begin
      OutI = head[2*SAMP_W-1:SAMP_W];
      OutQ = head[SAMP_W-1:0];
    end
  end

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Self-checking bench for iq_sample_fifo against a queue-based reference model.
module tb_iq_sample_fifo;

  localparam int SAMP_W   = 24;
  localparam int DEPTH    = 4;
  localparam int AFULL_TH = 3;
`ifdef IQ_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              Clk;
  logic              Reset;
  logic              PushIn;
  logic [SAMP_W-1:0] SampI;
  logic [SAMP_W-1:0] SampQ;
  logic              PullOut;
  logic [SAMP_W-1:0] OutI;
  logic [SAMP_W-1:0] OutQ;
  logic              Empty;
  logic              Full;
  logic              AlmostFull;
  logic [2:0]        Count;
  logic              ErrClr;
  logic              Overflow;
  logic              Underflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [2*SAMP_W-1:0] mq [$];
  bit m_ovf;
  bit m_udf;

  iq_sample_fifo #(
    .SAMP_W   (SAMP_W),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PushIn     (PushIn),
    .SampI      (SampI),
    .SampQ      (SampQ),
    .PullOut    (PullOut),
    .OutI       (OutI),
    .OutQ       (OutQ),
    .Empty      (Empty),
    .Full       (Full),
    .AlmostFull (AlmostFull),
    .Count      (Count),
    .ErrClr     (ErrClr),
    .Overflow   (Overflow),
    .Underflow  (Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One clock of stimulus; the model applies the FIFO rules to the same inputs.
  task automatic drive(input bit push, input logic [SAMP_W-1:0] i, input logic [SAMP_W-1:0] q,
                       input bit pull, input bit clr);
    bit full;
    bit acc_w;
    bit acc_r;
    logic [2*SAMP_W-1:0] tmp;
    PushIn  = push;
    SampI   = i;
    SampQ   = q;
    PullOut = pull;
    ErrClr  = clr;
    full  = (mq.size() == DEPTH);
    acc_w = push && (!full || pull);
    acc_r = pull && (mq.size() != 0);
    if (ERR_EN) begin
      if (push && full && !pull) m_ovf = 1'b1;
      else if (clr)              m_ovf = 1'b0;
      if (pull && mq.size() == 0) m_udf = 1'b1;
      else if (clr)               m_udf = 1'b0;
    end
    @(posedge Clk);
    if (acc_r) tmp = mq.pop_front();
    if (acc_w) mq.push_back({i, q});
    #1;
    PushIn  = 1'b0;
    PullOut = 1'b0;
    ErrClr  = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    n_cmp++;
    if (Empty !== 1'b1 || Count !== 3'd0 || Full !== 1'b0 || AlmostFull !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: Empty=%b Count=%0d Full=%b AF=%b, want 1 0 0 0", Empty, Count, Full, AlmostFull);
    end
    n_cmp++;
    if (OutI !== 24'h0 || OutQ !== 24'h0 || Overflow !== 1'b0 || Underflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: OutI=%h OutQ=%h Ovf=%b Udf=%b, want 0 0 0 0", OutI, OutQ, Overflow, Underflow);
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 24'h11 * (k + 1), 24'hAA + 24'h11 * k, 1'b0, 1'b0);
      n_cmp++;
      if (Count !== 3'(k + 1) || AlmostFull !== (k + 1 >= 3) || Full !== (k == 3) || Empty !== 1'b0) begin
        n_err++;
        $display("FAIL fill_%0d: Count=%0d AF=%b Full=%b Empty=%b, want %0d %b %b 0",
                 k, Count, AlmostFull, Full, Empty, k + 1, (k + 1 >= 3), (k == 3));
      end
      n_cmp++;
      if (OutI !== 24'h11 || OutQ !== 24'hAA) begin
        n_err++;
        $display("FAIL fill_head_%0d: OutI=%h OutQ=%h, want 000011 0000aa", k, OutI, OutQ);
      end
    end
  endtask

  task automatic test_overflow_drain();
    drive(1'b1, 24'h55, 24'hEE, 1'b0, 1'b0);
    n_cmp++;
    if (Count !== 3'd4 || Full !== 1'b1 || Overflow !== ERR_EN) begin
      n_err++;
      $display("FAIL overflow: Count=%0d Full=%b Ovf=%b, want 4 1 %b", Count, Full, Overflow, ERR_EN);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (OutI !== 24'h11 * (k + 1)) begin
        n_err++;
        $display("FAIL drain_%0d: OutI=%h, want %h", k, OutI, 24'h11 * (k + 1));
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
    end
    n_cmp++;
    if (Empty !== 1'b1 || Count !== 3'd0 || OutI !== 24'h0 || Underflow !== 1'b0) begin
      n_err++;
      $display("FAIL drained: Empty=%b Count=%0d OutI=%h Udf=%b, want 1 0 0 0", Empty, Count, OutI, Underflow);
    end
  endtask

  task automatic test_full_pushpull();
    logic [SAMP_W-1:0] exp_i [4];
    exp_i = '{24'h22, 24'h33, 24'h44, 24'h66};
    for (int k = 0; k < 4; k++) drive(1'b1, 24'h11 * (k + 1), 24'hAA + 24'h11 * k, 1'b0, 1'b0);
    drive(1'b1, 24'h66, 24'hFF, 1'b1, 1'b0);
    n_cmp++;
    if (Count !== 3'd4 || Full !== 1'b1) begin
      n_err++;
      $display("FAIL full_pushpull: Count=%0d Full=%b, want 4 1", Count, Full);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (OutI !== exp_i[k]) begin
        n_err++;
        $display("FAIL full_pp_pull_%0d: OutI=%h, want %h", k, OutI, exp_i[k]);
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
    end
    n_cmp++;
    if (Empty !== 1'b1) begin
      n_err++;
      $display("FAIL full_pp_empty: Empty=%b, want 1", Empty);
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (Overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: Ovf=%b, want 0", Overflow);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (Empty !== 1'b1 || Count !== 3'd0 || Underflow !== ERR_EN) begin
      n_err++;
      $display("FAIL underflow: Empty=%b Count=%0d Udf=%b, want 1 0 %b", Empty, Count, Underflow, ERR_EN);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    n_cmp++;
    if (Underflow !== ERR_EN) begin
      n_err++;
      $display("FAIL set_wins: Udf=%b, want %b", Underflow, ERR_EN);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (Underflow !== 1'b0) begin
      n_err++;
      $display("FAIL udf_clear: Udf=%b, want 0", Underflow);
    end
    // Pull on empty together with a push: only the push lands, no bypass.
    drive(1'b1, 24'h77, 24'h88, 1'b1, 1'b0);
    n_cmp++;
    if (Count !== 3'd1 || OutI !== 24'h77 || OutQ !== 24'h88) begin
      n_err++;
      $display("FAIL empty_pushpull: Count=%0d OutI=%h OutQ=%h, want 1 000077 000088", Count, OutI, OutQ);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_stream();
    logic [SAMP_W-1:0] prev_i;
    logic [SAMP_W-1:0] prev_q;
    logic [SAMP_W-1:0] ni;
    logic [SAMP_W-1:0] nq;
    prev_i = 24'($urandom);
    prev_q = 24'($urandom);
    drive(1'b1, prev_i, prev_q, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if (OutI !== prev_i || OutQ !== prev_q) begin
        n_err++;
        $display("FAIL stream_%0d: OutI=%h OutQ=%h, want %h %h", k, OutI, OutQ, prev_i, prev_q);
      end
      ni = 24'($urandom);
      nq = 24'($urandom);
      drive(1'b1, ni, nq, 1'b1, 1'b0);
      prev_i = ni;
      prev_q = nq;
      n_cmp++;
      if (Count !== 3'd1) begin
        n_err++;
        $display("FAIL stream_count_%0d: Count=%0d, want 1", k, Count);
      end
    end
    PushIn  = 1'b1;
    PullOut = 1'b1;
    SampI   = 24'h123456;
    #3 Reset = 1'b1;
    #1;
    n_cmp++;
    if (Empty !== 1'b1 || OutI !== 24'h0 || Count !== 3'd0) begin
      n_err++;
      $display("FAIL mid_reset: Empty=%b OutI=%h Count=%0d, want 1 0 0", Empty, OutI, Count);
    end
    @(posedge Clk);
    #2 Reset = 1'b0;
    PushIn  = 1'b0;
    PullOut = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    n_cmp++;
    if (Empty !== 1'b1 || Count !== 3'd0) begin
      n_err++;
      $display("FAIL post_reset: Empty=%b Count=%0d, want 1 0", Empty, Count);
    end
  endtask

  task automatic test_random();
    logic [2*SAMP_W-1:0] exp_head;
    int sz;
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 100) < 55, 24'($urandom), 24'($urandom),
            ($urandom % 100) < 45, ($urandom % 100) < 5);
      sz = mq.size();
      exp_head = (sz != 0) ? mq[0] : '0;
      n_cmp++;
      if (OutI !== exp_head[47:24] || OutQ !== exp_head[23:0] || Count !== 3'(sz) ||
          Empty !== (sz == 0) || Full !== (sz == DEPTH) || AlmostFull !== (sz >= AFULL_TH) ||
          Overflow !== m_ovf || Underflow !== m_udf) begin
        n_err++;
        $display("FAIL random_%0d: I=%h Q=%h Cnt=%0d E=%b F=%b AF=%b Ov=%b Ud=%b, want %h %h %0d %b %b %b %b %b",
                 k, OutI, OutQ, Count, Empty, Full, AlmostFull, Overflow, Underflow,
                 exp_head[47:24], exp_head[23:0], sz, (sz == 0), (sz == DEPTH), (sz >= AFULL_TH), m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    Reset   = 1'b0;
    PushIn  = 1'b0;
    PullOut = 1'b0;
    ErrClr  = 1'b0;
    SampI   = '0;
    SampQ   = '0;
    #1;
    test_reset();
    test_fill();
    test_overflow_drain();
    test_full_pushpull();
    test_underflow();
    test_stream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iq_sample_fifo.md
# iq_sample_fifo

Parametrised first-word-fall-through FIFO for complex (I/Q) samples, the buffering stage between the sample input interface and the downstream filter/processing pipeline. It generalises the fixed 4-entry, 24-bit sample FIFO:

- Sample width, depth and almost-full threshold are parameters.
- Push-on-full is guarded, and pull-on-empty is ignored rather than corrupting pointers.
- An occupancy count and an almost-full flag are provided for upstream flow control.
- Sticky overflow/underflow error flags are optional.

## Interface
Parameters:
- SAMP_W, 24, bit width of each of I and Q
- DEPTH, 4, number of entries; power of two, ≥ 2
- AFULL_TH, DEPTH-1, AlmostFull asserts when Count ≥ AFULL_TH; range 1..DEPTH

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- PushIn  in  1  write request
- SampI  in  SAMP_W  I sample to write
- SampQ  in  SAMP_W  Q sample to write
- PullOut  in  1  read request (consume head entry)
- OutI  out  SAMP_W  head-entry I; 0 when Empty
- OutQ  out  SAMP_W  head-entry Q; 0 when Empty
- Empty  out  1  no entries
- Full  out  1  Count == DEPTH
- AlmostFull  out  1  Count ≥ AFULL_TH
- Count  out  $clog2(DEPTH)+1  current occupancy
- ErrClr  in  1  clears sticky error flags
- Overflow  out  1  sticky: push dropped
- Underflow  out  1  sticky: pull while empty

Reset is Reset, asynchronous, active-high; the clock is Clk.

## Operation
- Storage is DEPTH entries of {I,Q}, indexed by read and write pointers of $clog2(DEPTH)+1 bits. The extra MSB is the wrap bit.
- Empty: pointers are equal.
- Full: low bits are equal and the MSBs differ.
- Count is write_ptr − read_ptr, modulo 2^(ptr width).
- Push accepted (accept_w) = PushIn && (!Full || PullOut).
  - On acceptance, the entry at the write pointer is loaded with {SampI, SampQ}, and the write pointer increments and wraps naturally.
- Pull accepted (accept_r) = PullOut && !Empty.
  - On acceptance, the read pointer increments.
- Simultaneous push and pull:
  - Not empty and not full: both are accepted and Count is unchanged.
  - Full: both are accepted. The freed slot is the one written (write index == read index), and the new data becomes visible after the old head is consumed.
  - Empty: only the push is accepted and Count becomes 1. There is no same-cycle bypass.
- Dropped push (PushIn && Full && !PullOut): pointers and storage are unchanged.
- Ignored pull (PullOut && Empty): pointers are unchanged.
- OutI/OutQ are driven combinationally from the entry at the read pointer, gated to 0 while Empty.
- Flags and Count are combinational functions of the registered pointers only, with no input-to-flag paths.

## Timing
- Reset values:
  - Pointers 0, Count 0, Empty 1, Full 0, AlmostFull 0 (AFULL_TH ≥ 1), OutI/OutQ 0, Overflow 0, Underflow 0.
  - Storage is not required to reset.
- Reset asserted mid-operation immediately empties the FIFO. Contents are discarded, and in-flight push/pull in that cycle have no effect.
- Write-to-read latency: a sample pushed at edge N appears on OutI/OutQ after edge N when the FIFO was empty. Empty deasserts in the same cycle.
- A pull at edge N presents the next entry after edge N. The consumer samples OutI/OutQ in the same cycle it asserts PullOut.
- Throughput is one push and one pull per cycle, sustained.
- Pointer wrap: after DEPTH accepted pushes, the write pointer MSB toggles. Continuous streaming over more than 2·DEPTH samples must not corrupt order.

## Configuration
- The macro is IQ_FIFO_ERR_EN.
- When defined:
  - Overflow is set on the edge after a dropped push.
  - Underflow is set on the edge after an ignored pull.
  - Both hold until ErrClr is asserted or Reset.
  - If a set event and ErrClr occur in the same cycle, set wins.
- When not defined:
  - No error registers are built.
  - Overflow and Underflow are tied to 0, and ErrClr is ignored.
  - Ports remain present so the bench is identical in both builds.

## Structure
- Shared package samp_pkg holds:
  - The default SAMP_W constant (24).
  - A parametrised-width note for the existing Samp {I,Q} struct typedef.
  - A helper constant for the default DEPTH.
- The sub-module fifo_ptr_ctl is natural. It holds:
  - Both pointers and the accept_w/accept_r logic.
  - The Empty/Full/Count/AlmostFull generation.
  - The optional error flags.
- The top level keeps storage and the output mux/gating.

## Test plan
Defaults are SAMP_W=24, DEPTH=4, AFULL_TH=3, built with IQ_FIFO_ERR_EN.
- Reset, then idle → Empty=1, Count=0, OutI=OutQ=0, Full=0, Overflow=0.
- Push I=0x000011/Q=0x0000AA … I=0x000044/Q=0x0000DD on 4 consecutive cycles → Count 1, 2, 3, 4; AlmostFull at Count=3; Full=1; OutI=0x000011 throughout.
- While full, push I=0x000055 without PullOut → dropped; Count stays 4; Overflow=1 next cycle. Then pull 4 times → OutI 0x11, 0x22, 0x33, 0x44 in order; Empty=1.
- Full, with PushIn and PullOut together (I=0x000066) → Count stays 4. The next 4 pulls yield 0x22, 0x33, 0x44, 0x66.
- Empty, with PullOut alone → no pointer change; Underflow=1. Then ErrClr for 1 cycle → Underflow=0.
- Stream 20 samples with push and pull every cycle after a 1-deep prefill → output sequence equals input delayed by one; Count stays 1. Assert Reset mid-stream → Empty=1, OutI=0 immediately.
